// File: rtl/led_strip_tx_pkg.sv
// Shared definitions for the LED strip output path: GRB colour constants,
// default 100 MHz WS2812 timing and the transmitter state encoding.
package led_strip_tx_pkg;

    localparam int LED_BITS = 24;

    // Colours packed G,R,B (most significant byte is green)
    localparam logic [LED_BITS-1:0] OFF    = 24'h00_00_00;
    localparam logic [LED_BITS-1:0] RED    = 24'h00_FF_00;
    localparam logic [LED_BITS-1:0] ORANGE = 24'hA5_FF_00;
    localparam logic [LED_BITS-1:0] GREEN  = 24'hFF_00_00;
    localparam logic [LED_BITS-1:0] CYAN   = 24'hFF_00_FF;
    localparam logic [LED_BITS-1:0] BLUE   = 24'h00_00_FF;
    localparam logic [LED_BITS-1:0] VIOLET = 24'h00_80_FF;

    localparam int NUM_LEDS_DEF = 5;
    localparam int T0H_DEF      = 40;
    localparam int T1H_DEF      = 80;
    localparam int TBIT_DEF     = 125;
    localparam int TRESET_DEF   = 6000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_LATCH = 2'd3
    } tx_state_t;

endpackage

// File: rtl/led_bit_timer.sv
// Per-bit cycle counter: flags the end of the high pulse (length chosen by
// the bit value) and the end of the full bit period.
module led_bit_timer #(
    parameter int T0H   = 40,
    parameter int T1H   = 80,
    parameter int TBIT  = 125,
    parameter int TMR_W = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic bit_val,
    output logic hi_last,
    output logic bit_last
);

    localparam logic [TMR_W-1:0] T0H_LAST  = TMR_W'(T0H - 1);
    localparam logic [TMR_W-1:0] T1H_LAST  = TMR_W'(T1H - 1);
    localparam logic [TMR_W-1:0] TBIT_LAST = TMR_W'(TBIT - 1);

    logic [TMR_W-1:0] cnt;

    // start wins over run so a new bit always begins counting from zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    assign hi_last  = (cnt == (bit_val ? T1H_LAST : T0H_LAST));
    assign bit_last = (cnt == TBIT_LAST);

endmodule

// File: rtl/led_strip_tx.sv
// WS2812-class serial transmitter: latches a GRB frame on Load, sends it MSB
// first as NRZ pulse-width bits, then holds the line low for the latch gap.
module led_strip_tx
    import led_strip_tx_pkg::*;
#(
    parameter int NUM_LEDS = NUM_LEDS_DEF,
    parameter int T0H      = T0H_DEF,
    parameter int T1H      = T1H_DEF,
    parameter int TBIT     = TBIT_DEF,
    parameter int TRESET   = TRESET_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LEDS*LED_BITS-1:0] GRBin,
    input  logic                         Load,
    output logic                         Dout,
    output logic                         Busy,
    output logic                         Done
);

    localparam int FRAME_W = NUM_LEDS * LED_BITS;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int TMR_MAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
    localparam logic [TMR_W-1:0] LAST_LATCH = TMR_W'(TRESET - 1);

    tx_state_t          state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]   bitcnt, bitcnt_n;
    logic [TMR_W-1:0]   lcnt, lcnt_n;
    logic               bit_start, bit_run, hi_last, bit_last;

    led_bit_timer #(
        .T0H   (T0H),
        .T1H   (T1H),
        .TBIT  (TBIT),
        .TMR_W (TMR_W)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (bit_start),
        .run      (bit_run),
        .bit_val  (shreg[FRAME_W-1]),
        .hi_last  (hi_last),
        .bit_last (bit_last)
    );

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        lcnt_n    = lcnt;
        bit_start = 1'b0;
        bit_run   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Load) begin
                    shreg_n   = GRBin;
                    bitcnt_n  = '0;
                    lcnt_n    = '0;
                    bit_start = 1'b1;
                    state_n   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                bit_run = 1'b1;
                if (hi_last) begin
                    state_n = ST_LOW;
                end
            end
            ST_LOW: begin
                bit_run = 1'b1;
                if (bit_last) begin
                    if (bitcnt == LAST_BIT) begin
                        lcnt_n  = '0;
                        state_n = ST_LATCH;
                    end else begin
                        shreg_n   = {shreg[FRAME_W-2:0], 1'b0};
                        bitcnt_n  = bitcnt + CNT_W'(1);
                        bit_start = 1'b1;
                        state_n   = ST_HIGH;
                    end
                end
            end
            ST_LATCH: begin
                if (lcnt == LAST_LATCH) begin
                    lcnt_n  = '0;
                    state_n = ST_IDLE;
                end else begin
                    lcnt_n = lcnt + TMR_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            lcnt   <= '0;
            Dout   <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            bitcnt <= bitcnt_n;
            lcnt   <= lcnt_n;
            Dout   <= (state_n == ST_HIGH);
            Busy   <= (state_n != ST_IDLE);
            Done   <= (state_n == ST_LATCH) && (lcnt_n == LAST_LATCH);
        end
    end

endmodule
